// File: rtl/arm_defs.sv
// Shared encodings for the ARM-subset pipeline: ALU commands, instruction modes,
// data-processing opcodes, condition codes and status-register bit positions.
package arm_defs;

   localparam logic [3:0] EXE_CMD_NOP = 4'b0000;
   localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
   localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
   localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
   localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
   localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
   localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
   localparam logic [3:0] EXE_CMD_AND = 4'b0110;
   localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
   localparam logic [3:0] EXE_CMD_EOR = 4'b1000;

   localparam logic [1:0] MODE_ARITH  = 2'b00;
   localparam logic [1:0] MODE_MEM    = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;

   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_TST = 4'b1000;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam int STATUS_N = 3;
   localparam int STATUS_Z = 2;
   localparam int STATUS_C = 1;
   localparam int STATUS_V = 0;

endpackage

// File: rtl/register_file.sv
// Architectural register file: synchronous write, async clear, two combinational
// read ports that see a same-cycle write. Index REG_COUNT (R15) reads as zero.
module register_file #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [3:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [3:0]        rd_addr_a,
   input  logic [3:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [DATA_W-1:0] regs [REG_COUNT];
   logic              wr_ok;

   assign wr_ok = wr_en && (int'(wr_addr) < REG_COUNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Bypass lets WB and ID share a cycle without a extra forwarding stall.
   assign rd_data_a = (int'(rd_addr_a) >= REG_COUNT)       ? '0      :
                      (wr_ok && (rd_addr_a == wr_addr))     ? wr_data :
                                                              regs[rd_addr_a];
   assign rd_data_b = (int'(rd_addr_b) >= REG_COUNT)       ? '0      :
                      (wr_ok && (rd_addr_b == wr_addr))     ? wr_data :
                                                              regs[rd_addr_b];

endmodule

// File: rtl/id_stage.sv
// Decode stage: control decode, condition evaluation, register read, and the
// ID/EX pipeline register. Source IDs leave combinationally for the hazard unit.
module id_stage import arm_defs::*; #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze_in,
   input  logic              flush_in,
   input  logic [31:0]       instruction_in,
   input  logic [DATA_W-1:0] pc_plus_four_in,
   input  logic [3:0]        status_in,
   input  logic              wb_en_in,
   input  logic [3:0]        wb_dest_in,
   input  logic [DATA_W-1:0] wb_value_in,
   output logic [3:0]        src1_out,
   output logic [3:0]        src2_out,
   output logic              two_src_out,
   output logic [DATA_W-1:0] pc_out,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic              mem_w_en_out,
   output logic              branch_out,
   output logic              s_out,
   output logic [3:0]        exe_cmd_out,
   output logic [DATA_W-1:0] val_rn_out,
   output logic [DATA_W-1:0] val_rm_out,
   output logic              imm_out,
   output logic [11:0]       shift_operand_out,
   output logic [23:0]       imm24_out,
   output logic [3:0]        dest_out,
   output logic              carry_out
);

   logic [3:0]        cond_p0;
   logic [1:0]        mode_p0;
   logic [3:0]        op_p0;
   logic              s_bit_p0;
   logic              imm_bit_p0;
   logic              wb_en_p0;
   logic              mem_r_en_p0;
   logic              mem_w_en_p0;
   logic              branch_p0;
   logic              s_p0;
   logic [3:0]        exe_cmd_p0;
   logic              cond_ok_p0;
   logic              bubble_p0;
   logic [DATA_W-1:0] val_rn_p0;
   logic [DATA_W-1:0] val_rm_p0;

   assign cond_p0    = instruction_in[31:28];
   assign mode_p0    = instruction_in[27:26];
   assign imm_bit_p0 = instruction_in[25];
   assign op_p0      = instruction_in[24:21];
   assign s_bit_p0   = instruction_in[20];

   always_comb begin
      wb_en_p0    = 1'b0;
      mem_r_en_p0 = 1'b0;
      mem_w_en_p0 = 1'b0;
      branch_p0   = 1'b0;
      s_p0        = 1'b0;
      exe_cmd_p0  = EXE_CMD_NOP;
      case (mode_p0)
         MODE_ARITH: begin
            wb_en_p0 = 1'b1;
            s_p0     = s_bit_p0;
            case (op_p0)
               OP_MOV:  exe_cmd_p0 = EXE_CMD_MOV;
               OP_MVN:  exe_cmd_p0 = EXE_CMD_MVN;
               OP_ADD:  exe_cmd_p0 = EXE_CMD_ADD;
               OP_ADC:  exe_cmd_p0 = EXE_CMD_ADC;
               OP_SUB:  exe_cmd_p0 = EXE_CMD_SUB;
               OP_SBC:  exe_cmd_p0 = EXE_CMD_SBC;
               OP_AND:  exe_cmd_p0 = EXE_CMD_AND;
               OP_ORR:  exe_cmd_p0 = EXE_CMD_ORR;
               OP_EOR:  exe_cmd_p0 = EXE_CMD_EOR;
               OP_CMP: begin
                  exe_cmd_p0 = EXE_CMD_SUB;
                  wb_en_p0   = 1'b0;
               end
               OP_TST: begin
                  exe_cmd_p0 = EXE_CMD_AND;
                  wb_en_p0   = 1'b0;
               end
               default: begin
                  wb_en_p0 = 1'b0;
                  s_p0     = 1'b0;
               end
            endcase
         end
         MODE_MEM: begin
            exe_cmd_p0  = EXE_CMD_ADD;
            mem_r_en_p0 = s_bit_p0;
            wb_en_p0    = s_bit_p0;
            mem_w_en_p0 = ~s_bit_p0;
         end
         MODE_BRANCH: branch_p0 = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cond_ok_p0 = 1'b0;
      case (cond_p0)
         COND_EQ: cond_ok_p0 = status_in[STATUS_Z];
         COND_NE: cond_ok_p0 = ~status_in[STATUS_Z];
         COND_CS: cond_ok_p0 = status_in[STATUS_C];
         COND_CC: cond_ok_p0 = ~status_in[STATUS_C];
         COND_MI: cond_ok_p0 = status_in[STATUS_N];
         COND_PL: cond_ok_p0 = ~status_in[STATUS_N];
         COND_VS: cond_ok_p0 = status_in[STATUS_V];
         COND_VC: cond_ok_p0 = ~status_in[STATUS_V];
         COND_HI: cond_ok_p0 = status_in[STATUS_C] & ~status_in[STATUS_Z];
         COND_LS: cond_ok_p0 = ~status_in[STATUS_C] | status_in[STATUS_Z];
         COND_GE: cond_ok_p0 = (status_in[STATUS_N] == status_in[STATUS_V]);
         COND_LT: cond_ok_p0 = (status_in[STATUS_N] != status_in[STATUS_V]);
         COND_GT: cond_ok_p0 = ~status_in[STATUS_Z] &
                               (status_in[STATUS_N] == status_in[STATUS_V]);
         COND_LE: cond_ok_p0 = status_in[STATUS_Z] |
                               (status_in[STATUS_N] != status_in[STATUS_V]);
         COND_AL: cond_ok_p0 = 1'b1;
         default: cond_ok_p0 = 1'b0;
      endcase
   end

   // STR carries its store data in Rd, so the second read port follows the raw decode.
   assign src1_out    = instruction_in[19:16];
   assign src2_out    = mem_w_en_p0 ? instruction_in[15:12] : instruction_in[3:0];
   assign two_src_out = ~imm_bit_p0 | mem_w_en_p0;
   assign bubble_p0   = ~cond_ok_p0 | freeze_in;

   register_file #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT)
   ) u_register_file (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wb_en_in),
      .wr_addr   (wb_dest_in),
      .wr_data   (wb_value_in),
      .rd_addr_a (src1_out),
      .rd_addr_b (src2_out),
      .rd_data_a (val_rn_p0),
      .rd_data_b (val_rm_p0)
   );

   // ---- ID/EX boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush_in) begin
         pc_out            <= '0;
         wb_en_out         <= 1'b0;
         mem_r_en_out      <= 1'b0;
         mem_w_en_out      <= 1'b0;
         branch_out        <= 1'b0;
         s_out             <= 1'b0;
         exe_cmd_out       <= EXE_CMD_NOP;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         imm_out           <= 1'b0;
         shift_operand_out <= '0;
         imm24_out         <= '0;
         dest_out          <= '0;
         carry_out         <= 1'b0;
      end else begin
         pc_out            <= pc_plus_four_in;
         val_rn_out        <= val_rn_p0;
         val_rm_out        <= val_rm_p0;
         imm_out           <= imm_bit_p0;
         shift_operand_out <= instruction_in[11:0];
         imm24_out         <= instruction_in[23:0];
         dest_out          <= instruction_in[15:12];
         carry_out         <= status_in[STATUS_C];
         wb_en_out         <= wb_en_p0    & ~bubble_p0;
         mem_r_en_out      <= mem_r_en_p0 & ~bubble_p0;
         mem_w_en_out      <= mem_w_en_p0 & ~bubble_p0;
         branch_out        <= branch_p0   & ~bubble_p0;
         s_out             <= s_p0        & ~bubble_p0;
         exe_cmd_out       <= bubble_p0 ? EXE_CMD_NOP : exe_cmd_p0;
      end
   end

endmodule
